data_mem: RTL
=============

# data_mem

Synchronous on-chip data RAM sitting directly downstream of the memory stage: it consumes that stage's row-aligned load/store request, row byte index and access size. It performs byte-lane-strobed stores and returns full 64-bit rows for loads after a fixed, parameterised read latency. After reset it clears its contents with a row-by-row sweep before accepting traffic. Load extraction and sign extension are done by writeback, using the row index the memory stage forwards.

## Interface
- MEM_BYTES, 524288: capacity in bytes; power of two, ≥ 64; ROWS = MEM_BYTES/8.
- RD_LATENCY, 1: accept-to-data cycles for reads; legal 1..3.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_i  in  1  request strobe (memory-stage data_mem_req)
- addr_i  in  64  row-aligned byte address; bits [2:0] ignored
- wr_i  in  1  1 = store, 0 = load
- size_i  in  2  cpu_consts access size: BYTE, HALF_WORD, WORD, DOUBLE_WORD
- row_idx_i  in  3  starting byte lane within the row
- wr_data_i  in  64  store value, right-justified (LSB in bit 0)
- ready_o  out  1  block accepts requests this cycle
- rd_valid_o  out  1  one-cycle pulse: rd_data_o carries a load result
- rd_data_o  out  64  full row read data; holds last value between pulses

## Operation
- Row index = addr_i[$clog2(MEM_BYTES)-1:3]. Upper bits are ignored because the memory stage already suppresses out-of-bounds requests.
- Accept = req_i & ready_o. Requests while ready_o = 0 are dropped silently. No queueing and no error.
- FSM states: INIT, RUN.
  - Reset forces INIT with the clear counter at 0.
  - INIT writes 64'h0 to row[counter] and increments the counter each cycle. At counter = ROWS-1 that row is written and the state goes to RUN on the next edge.
  - RUN persists until reset. ready_o = (state == RUN).
- Store strobe (8 bits), before shift: BYTE 8'h01, HALF_WORD 8'h03, WORD 8'h0F, DOUBLE_WORD 8'hFF.
  - Shifted left by row_idx_i.
  - Bits shifted past lane 7 are discarded.
  - Lane data = wr_data_i << (8*row_idx_i), truncated to 64 bits.
- A store writes only strobed bytes on the accept edge. Stores produce no response.
- A load reads the row on the accept edge. The value enters a RD_LATENCY-deep valid/data pipeline; stage 1 is the RAM output register.
- Pipeline stages advance every cycle with no stall. A new load may be accepted every cycle.
- Ordering is read-first:
  - A load samples row contents as of its accept cycle.
  - A store accepted one cycle later does not alter that load's in-flight result.
  - A load accepted the cycle after a store to the same row sees the stored bytes.

## Timing
- Reset values: ready_o = 0, rd_valid_o = 0, rd_data_o = 64'h0. All pipeline valid bits are cleared and the clear counter is set to 0.
- After reset deasserts at edge E0, INIT runs for ROWS cycles. ready_o rises after edge E0+ROWS.
- A load accepted at edge N: rd_valid_o = 1 and rd_data_o = row value during cycle N+RD_LATENCY (between edges N+RD_LATENCY and N+RD_LATENCY+1).
- A store accepted at edge N: RAM updated at edge N and visible to a load accepted at edge N+1.
- Reset asserted mid-operation:
  - In-flight loads are discarded, so no rd_valid_o pulse occurs.
  - INIT restarts from row 0. A partially completed sweep is restarted, not resumed.
- Reset dominates every other input in the same cycle.
- Misaligned size/row_idx combinations are flagged upstream. Here they write only the in-row lanes, with no wrap into the next row.

## Test plan
- Init sweep (MEM_BYTES=256, 32 rows): ready_o = 0 for exactly 32 cycles after reset deasserts. Reads of rows 0, 15 and 31 then return 64'h0.
- Byte store: DOUBLE_WORD 64'h1122334455667788 to addr 0x40, then BYTE 0xAB with row_idx 5 to addr 0x40. A read of 0x40 returns 64'h1122AB4455667788.
- Half-word and word lanes: HALF_WORD 0x1234 at row_idx 6 on the same row gives 64'h1234AB4455667788. A following WORD 0xDEADBEEF at row_idx 0 gives 64'h1234AB44DEADBEEF.
- Pipelining (RD_LATENCY=2): back-to-back loads of rows A, B, C on consecutive edges produce three consecutive rd_valid_o pulses, starting 2 cycles after the first accept, with data in order A, B, C. Next, store to row A one cycle after a load of A is accepted; that load returns the old value.
- Gating: req_i held high during INIT produces no RAM writes and no rd_valid_o pulse. Stores issued during INIT are not visible after INIT completes.
- Mid-op reset: assert reset one cycle after a load accept with RD_LATENCY=3. The bench requires no rd_valid_o pulse, outputs at reset values, and a full 32-cycle INIT before ready_o rises; a prior store's data then reads back as 0.

Source files
------------

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
//
// Synchronous on-chip data RAM fed by the memory stage. Stores are byte-lane
// strobed inside a single 64-bit row. Loads return the whole row after
// RD_LATENCY cycles; lane extraction and sign extension happen in writeback.
// After reset the array is cleared one row per cycle before traffic is
// accepted.
//
// Parameters
//   MEM_BYTES   capacity in bytes (power of two, >= 64); ROWS = MEM_BYTES/8
//   RD_LATENCY  accept-to-data cycles for loads (1..3)
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   req_i       request strobe from the memory stage
//   addr_i      row-aligned byte address (bits [2:0] ignored)
//   wr_i        1 = store, 0 = load
//   size_i      access size: 0 BYTE, 1 HALF_WORD, 2 WORD, 3 DOUBLE_WORD
//   row_idx_i   starting byte lane within the row
//   wr_data_i   right-justified store value
//   ready_o     block accepts requests this cycle
//   rd_valid_o  one-cycle pulse, rd_data_o carries a load result
//   rd_data_o   full row read data, holds its value between pulses
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int MEM_BYTES  = 524288,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [63:0] addr_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [2:0]  row_idx_i,
    input  logic [63:0] wr_data_i,
    output logic        ready_o,
    output logic        rd_valid_o,
    output logic [63:0] rd_data_o
);

    localparam int ROWS   = MEM_BYTES / 8;
    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam int ROW_W  = ADDR_W - 3;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e            state_q;
    logic [ROW_W-1:0]  clr_cnt_q;
    logic              ready_q;

    logic [63:0]       mem_q [ROWS];

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [63:0]           pipe_data_q [RD_LATENCY];
    logic                  rd_valid_q;
    logic [63:0]           rd_data_q;

    logic              accept;
    logic              store_en;
    logic              load_en;
    logic [ROW_W-1:0]  row_sel;
    logic [7:0]        base_strb;
    logic [7:0]        wr_strb;
    logic [63:0]       wr_lane_data;

    // Request qualification. Address bits above the array size are ignored
    // because the memory stage already filters out-of-range accesses.
    always_comb begin
        accept   = req_i & ready_q;
        store_en = accept & wr_i;
        load_en  = accept & ~wr_i;
        row_sel  = addr_i[ADDR_W-1:3];
    end

    // Byte-lane strobe and lane-aligned store data. Lanes pushed past byte 7
    // fall off the 8-bit strobe, so misaligned accesses never wrap into the
    // next row.
    always_comb begin
        base_strb = 8'h00;
        case (size_i)
            SIZE_BYTE:   base_strb = 8'h01;
            SIZE_HALF:   base_strb = 8'h03;
            SIZE_WORD:   base_strb = 8'h0F;
            SIZE_DOUBLE: base_strb = 8'hFF;
            default:     base_strb = 8'h00;
        endcase
        wr_strb      = base_strb << row_idx_i;
        wr_lane_data = wr_data_i << {row_idx_i, 3'b000};
    end

    // Control FSM. INIT walks the clear counter over every row; the edge that
    // clears the last row also moves to RUN, which lasts until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    clr_cnt_q <= clr_cnt_q + ROW_W'(1);
                    if (clr_cnt_q == LAST_ROW) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM array. The clear sweep owns the write port during INIT; in RUN only
    // strobed lanes of an accepted store are written. Reset blocks all writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (store_en) begin
                for (int b = 0; b < 8; b++) begin
                    if (wr_strb[b]) begin
                        mem_q[row_sel][8*b +: 8] <= wr_lane_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline. Stage 0 captures the row on the accept edge, before any
    // store on a later edge can change it, which gives read-first ordering.
    // Data registers only load alongside a valid bit so the output holds the
    // last result between pulses. Reset drops every in-flight load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            pipe_vld_q[0] <= load_en;
            if (load_en) begin
                pipe_data_q[0] <= mem_q[row_sel];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                if (pipe_vld_q[k-1]) begin
                    pipe_data_q[k] <= pipe_data_q[k-1];
                end
            end
            rd_valid_q <= pipe_vld_q[RD_LATENCY-1];
            if (pipe_vld_q[RD_LATENCY-1]) begin
                rd_data_q <= pipe_data_q[RD_LATENCY-1];
            end
        end
    end

    assign ready_o    = ready_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
